// File: rtl/spart_pkg.sv
// Shared constants for the spart processor-side driver: bus addresses,
// sequencer states and the baud divisor calculation.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        RD,
        WR,
        GAP
    } state_t;

    localparam int unsigned BAUD_4800  = 4800;
    localparam int unsigned BAUD_9600  = 9600;
    localparam int unsigned BAUD_19200 = 19200;
    localparam int unsigned BAUD_38400 = 38400;

    // spart oversamples by 16 and counts the divisor down to zero, hence the -1.
    function automatic logic [15:0] baud_divisor(input int unsigned clk_hz,
                                                 input logic [1:0]  sel);
        int unsigned baud;
        case (sel)
            2'b00:   baud = BAUD_4800;
            2'b01:   baud = BAUD_9600;
            2'b10:   baud = BAUD_19200;
            default: baud = BAUD_38400;
        endcase
        return 16'(clk_hz / (16 * baud) - 1);
    endfunction

endpackage

// File: rtl/spart_if.sv
// Control and status strobes between the processor-side driver and the spart.
// The shared data bus stays a plain inout so tri-state resolution is kept at port level.
interface spart_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, iorw, ioaddr, input rda, tbr);
    modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_driver_fifo.sv
// Echo buffer: small synchronous FIFO with a combinational head, flush and exact occupancy.
module echo_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Depth is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/spart_driver.sv
// Processor-side bus master for the spart: loads the baud divisor whenever the
// switches change, then echoes received bytes back through a small FIFO.
module spart_driver
    import spart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    br_cfg,
    spart_if.master                       bus,
    inout  wire  [7:0]                    databus,
    output logic                          cfg_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t          state_reg, state_next;
    logic [GW-1:0]   gap_cnt_reg, gap_cnt_next;
    logic            from_lo_reg, from_lo_next;
    logic [1:0]      sync1_reg, sync2_reg;
    logic [1:0]      snap_reg, snap_next;
    logic            cfg_done_reg, cfg_done_next;
    logic            iocs_reg, iocs_next;
    logic            iorw_reg, iorw_next;
    logic [1:0]      ioaddr_reg, ioaddr_next;
    logic [7:0]      data_reg, data_next;

    logic            fifo_flush;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [7:0]      fifo_head;
    logic [15:0]     div_tab [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_div
        assign div_tab[gi] = baud_divisor(CLK_HZ, 2'(gi));
    end

    // A transaction closes at the edge that ends the cycle in which it was on the bus.
    assign fifo_push = (state_reg == RD);
    assign fifo_pop  = (state_reg == WR);

    echo_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (databus),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // state_reg names the phase currently on the bus; outputs are registered
    // from state_next so they line up with it. CFG_LO with iocs low only occurs
    // straight after reset and means "issue the low-byte write now".
    always_comb begin
        state_next    = state_reg;
        gap_cnt_next  = gap_cnt_reg;
        from_lo_next  = from_lo_reg;
        cfg_done_next = cfg_done_reg;
        snap_next     = snap_reg;
        fifo_flush    = 1'b0;

        case (state_reg)
            CFG_LO: begin
                if (iocs_reg) begin
                    state_next   = GAP;
                    gap_cnt_next = '0;
                    from_lo_next = 1'b1;
                end
            end
            CFG_HI: begin
                state_next    = GAP;
                gap_cnt_next  = '0;
                from_lo_next  = 1'b0;
                cfg_done_next = 1'b1;
            end
            IDLE: begin
                if (sync2_reg != snap_reg) begin
                    cfg_done_next = 1'b0;
                    fifo_flush    = 1'b1;
                    state_next    = CFG_LO;
                end else if (bus.tbr && !fifo_empty) begin
                    state_next = WR;
                end else if (bus.rda && !fifo_full) begin
                    state_next = RD;
                end
            end
            RD, WR: begin
                state_next   = GAP;
                gap_cnt_next = '0;
                from_lo_next = 1'b0;
            end
            GAP: begin
                if (gap_cnt_reg == GW'(GAP_CYCLES - 1)) begin
                    state_next = from_lo_reg ? CFG_HI : IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next == CFG_LO) begin
            snap_next = sync2_reg;
        end

        iocs_next   = 1'b0;
        iorw_next   = 1'b1;
        ioaddr_next = ADDR_BUF;
        data_next   = data_reg;
        case (state_next)
            CFG_LO: begin
                iocs_next   = 1'b1;
                iorw_next   = 1'b0;
                ioaddr_next = ADDR_DBL;
                data_next   = div_tab[snap_next][7:0];
            end
            CFG_HI: begin
                iocs_next   = 1'b1;
                iorw_next   = 1'b0;
                ioaddr_next = ADDR_DBH;
                data_next   = div_tab[snap_next][15:8];
            end
            RD: begin
                iocs_next = 1'b1;
            end
            WR: begin
                iocs_next = 1'b1;
                iorw_next = 1'b0;
                data_next = fifo_head;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= CFG_LO;
            gap_cnt_reg  <= '0;
            from_lo_reg  <= 1'b0;
            sync1_reg    <= 2'b00;
            sync2_reg    <= 2'b00;
            snap_reg     <= 2'b00;
            cfg_done_reg <= 1'b0;
            iocs_reg     <= 1'b0;
            iorw_reg     <= 1'b1;
            ioaddr_reg   <= ADDR_BUF;
            data_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            gap_cnt_reg  <= gap_cnt_next;
            from_lo_reg  <= from_lo_next;
            sync1_reg    <= br_cfg;
            sync2_reg    <= sync1_reg;
            snap_reg     <= snap_next;
            cfg_done_reg <= cfg_done_next;
            iocs_reg     <= iocs_next;
            iorw_reg     <= iorw_next;
            ioaddr_reg   <= ioaddr_next;
            data_reg     <= data_next;
        end
    end

    // spart drives the bus whenever iorw is high, so only a write cycle may drive it.
    assign databus    = iorw_reg ? 8'hzz : data_reg;
    assign bus.iocs   = iocs_reg;
    assign bus.iorw   = iorw_reg;
    assign bus.ioaddr = ioaddr_reg;
    assign cfg_done   = cfg_done_reg;

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: models the spart side (rx byte queue, tbr level) and
// checks every bus cycle against a queue-based echo model.
module tb_spart_driver;
    localparam int GAP   = 2;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [1:0] br_cfg;
    logic       cfg_done;
    logic [2:0] fifo_count;
    logic [7:0] rx_head;
    wire  [7:0] databus;

    spart_if sif ();

    spart_driver #(
        .CLK_HZ     (100_000_000),
        .FIFO_DEPTH (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .bus        (sif),
        .databus    (databus),
        .cfg_done   (cfg_done),
        .fifo_count (fifo_count)
    );

    // The spart side only drives during a read strobe.
    assign databus = (sif.iocs && sif.iorw) ? rx_head : 8'hzz;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_txn = -100;
    int lo_cyc   = 0;
    int rd_cyc   = 0;
    bit hi_pending = 0;
    logic [7:0]  last_lo;
    logic [15:0] last_div;
    logic [7:0]  rx_q [$];
    logic [7:0]  model_q [$];
    logic [7:0]  tx_log [$];
    logic [15:0] div_tab [4] = '{16'h0515, 16'h028A, 16'h0144, 16'h00A1};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic refresh_spart();
        sif.rda = (rx_q.size() != 0);
        rx_head = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    endtask

    task automatic offer(input logic [7:0] b);
        rx_q.push_back(b);
        refresh_spart();
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Bus monitor: one line per transaction, model updated from the spec's rules.
    initial begin : monitor
        logic [7:0] exp_b;
        logic [7:0] tmp;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                model_q.delete();
                rx_q.delete();
                refresh_spart();
                last_txn   = -100;
                hi_pending = 0;
                continue;
            end
            if (hi_pending) begin
                check_val("cfg_done_set", cfg_done, 1);
                hi_pending = 0;
            end
            if (sif.iocs && !sif.iorw && sif.ioaddr == 2'b10) model_q.delete();
            check_val("fifo_count", fifo_count, model_q.size());
            if (sif.iocs) begin
                check_val("bus_gap", (cyc - last_txn) >= GAP + 1, 1);
                last_txn = cyc;
                case (sif.ioaddr)
                    2'b00: begin
                        if (sif.iorw) begin
                            $display("cyc %0d: RD  0x%02h", cyc, rx_head);
                            check_val("rd_rda", sif.rda, 1);
                            check_val("rd_full", model_q.size() < DEPTH, 1);
                            check_val("rd_prio", sif.tbr && model_q.size() != 0, 0);
                            if (rx_q.size() != 0) model_q.push_back(rx_q[0]);
                            rd_cyc = cyc;
                            @(posedge clk);
                            #1;
                            if (!rst && rx_q.size() != 0) tmp = rx_q.pop_front();
                            refresh_spart();
                        end else begin
                            $display("cyc %0d: WR  0x%02h", cyc, databus);
                            check_val("wr_tbr", sif.tbr, 1);
                            check_val("wr_nonempty", model_q.size() != 0, 1);
                            if (model_q.size() != 0) begin
                                exp_b = model_q.pop_front();
                                check_val("wr_data", databus, exp_b);
                            end
                            tx_log.push_back(databus);
                        end
                    end
                    2'b10: begin
                        $display("cyc %0d: DBL 0x%02h", cyc, databus);
                        check_val("dbl_wr", sif.iorw, 0);
                        check_val("dbl_cfg_done", cfg_done, 0);
                        last_lo = databus;
                        lo_cyc  = cyc;
                    end
                    2'b11: begin
                        $display("cyc %0d: DBH 0x%02h", cyc, databus);
                        check_val("dbh_wr", sif.iorw, 0);
                        check_val("dbh_after_dbl", cyc - lo_cyc, GAP + 1);
                        last_div   = {databus, last_lo};
                        hi_pending = 1;
                    end
                    default: check_val("addr_stat", sif.ioaddr, 0);
                endcase
            end
        end
    end

    task automatic wait_config(input logic [1:0] cfg);
        int stable = 0;
        int budget = 0;
        while (stable < 12 && budget < 400) begin
            @(negedge clk);
            stable = cfg_done ? stable + 1 : 0;
            budget++;
        end
        check_val("cfg_timeout", stable >= 12, 1);
        check_val("cfg_div", last_div, div_tab[cfg]);
        #1;
    endtask

    task automatic wait_tx(input int n);
        int budget = 0;
        while (tx_log.size() < n && budget < 400) begin
            step();
            budget++;
        end
        check_val("tx_count", tx_log.size(), n);
    endtask

    task automatic wait_count(input int n);
        int budget = 0;
        while (fifo_count != n && budget < 200) begin
            step();
            budget++;
        end
        check_val("fifo_fill", fifo_count, n);
    endtask

    initial begin : stimulus
        int base;
        int set_cyc;
        int budget;
        rst = 1'b1;
        br_cfg = 2'b00;
        sif.tbr = 1'b0;
        refresh_spart();

        // Reset values
        repeat (3) step();
        check_val("rst_iocs", sif.iocs, 0);
        check_val("rst_iorw", sif.iorw, 1);
        check_val("rst_ioaddr", sif.ioaddr, 0);
        check_val("rst_cfg_done", cfg_done, 0);
        check_val("rst_fifo_count", fifo_count, 0);
        rst = 1'b0;
        @(negedge clk);
        check_val("first_iocs", sif.iocs, 1);
        check_val("first_addr", sif.ioaddr, 2);
        wait_config(2'b00);

        // Switch to 9600 baud
        br_cfg = 2'b01;
        wait_config(2'b01);

        // Single echo with read latency
        sif.tbr = 1'b1;
        base = tx_log.size();
        step();
        offer(8'h41);
        set_cyc = cyc;
        wait_tx(base + 1);
        check_val("echo_41", tx_log[base], 8'h41);
        check_val("rd_latency", rd_cyc - set_cyc, 1);

        // FIFO fills to depth, fifth byte stays in spart
        sif.tbr = 1'b0;
        for (int i = 0; i < 5; i++) offer(8'(8'h10 + i));
        repeat (60) step();
        check_val("full_count", fifo_count, DEPTH);
        check_val("full_pending", rx_q.size(), 1);
        check_val("full_rda", sif.rda, 1);
        base = tx_log.size();
        sif.tbr = 1'b1;
        wait_tx(base + 5);
        for (int i = 0; i < 5; i++) check_val("order", tx_log[base + i], 8'(8'h10 + i));

        // Write has priority over read
        sif.tbr = 1'b0;
        offer(8'h21);
        offer(8'h22);
        wait_count(2);
        base = tx_log.size();
        offer(8'h23);
        sif.tbr = 1'b1;
        wait_tx(base + 3);
        check_val("prio_0", tx_log[base], 8'h21);
        check_val("prio_1", tx_log[base + 1], 8'h22);
        check_val("prio_2", tx_log[base + 2], 8'h23);

        // br_cfg change flushes the FIFO and reloads the divisor
        sif.tbr = 1'b0;
        offer(8'h31);
        offer(8'h32);
        wait_count(2);
        br_cfg = 2'b11;
        wait_config(2'b11);
        check_val("flush_count", fifo_count, 0);
        base = tx_log.size();
        sif.tbr = 1'b1;
        repeat (20) step();
        check_val("no_flushed_echo", tx_log.size(), base);

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            step();
            if ($urandom_range(3) == 0 && rx_q.size() < 6) offer(8'($urandom_range(255)));
            if ($urandom_range(7) == 0) sif.tbr = 1'($urandom_range(1));
            if ($urandom_range(199) == 0) br_cfg = 2'($urandom_range(3));
        end
        sif.tbr = 1'b1;
        budget = 0;
        while ((rx_q.size() != 0 || fifo_count != 0) && budget < 600) begin
            step();
            budget++;
        end
        check_val("drain", rx_q.size() + int'(fifo_count), 0);
        wait_config(br_cfg);

        // Reset in the middle of a write
        sif.tbr = 1'b0;
        br_cfg = 2'b10;
        wait_config(2'b10);
        offer(8'h51);
        offer(8'h52);
        wait_count(2);
        sif.tbr = 1'b1;
        budget = 0;
        while (budget < 100) begin
            @(negedge clk);
            if (sif.iocs && !sif.iorw && sif.ioaddr == 2'b00) break;
            budget++;
        end
        check_val("wr_seen", budget < 100, 1);
        #1;
        rst = 1'b1;
        #1;
        check_val("mid_rst_iocs", sif.iocs, 0);
        check_val("mid_rst_iorw", sif.iorw, 1);
        check_val("mid_rst_count", fifo_count, 0);
        check_val("mid_rst_cfg_done", cfg_done, 0);
        repeat (2) step();
        rst = 1'b0;
        wait_config(2'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
